route_split_ctrl: RTL and testbench
===================================

Name: route_split_ctrl

Overview:
- Synchronous route-computation and sequencing controller for the router's 1-to-5 split stage (four mesh ports plus local core port).
- Accepts one flit at a time over a valid/ready handshake and decodes the destination from the header using XY dimension-order routing.
- Produces the registered port select and core select that drive the split datapath, then holds the flit until the chosen output accepts it.
- Sits between the router input buffer and the split datapath, replacing free-running control-channel generation.

Parameters:
- WIDTH, 11, flit width in bits. Bits [WIDTH-1:WIDTH-2] are dest_x, bits [WIDTH-3:WIDTH-4] are dest_y, remaining bits are payload.
- MESH_X, 4, number of mesh columns; valid dest_x is 0..MESH_X-1.
- MESH_Y, 4, number of mesh rows; valid dest_y is 0..MESH_Y-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- local_x  in  2  this router's X coordinate; quasi-static, sampled at every flit capture
- local_y  in  2  this router's Y coordinate; quasi-static, sampled at every flit capture
- in_valid  in  1  input flit valid
- in_ready  out  1  controller can accept a flit
- in_data  in  WIDTH  input flit
- out_data  out  WIDTH  registered flit presented to the split datapath
- out_sel  out  2  port select: 00 east, 01 west, 10 north, 11 south
- out_core  out  1  1 = deliver to local core; out_sel is don't-care
- out_valid  out  5  one-hot valid: [3:0] mesh ports, [4] core
- out_ready  in  5  per-output ready, same bit order as out_valid
- route_err  out  1  sticky flag: a flit carried an out-of-range destination

Behaviour:
- Reset values: in_ready=0 during reset and 1 in the first cycle after; out_valid=0; out_sel=00; out_core=0; out_data=0; route_err=0; FSM in IDLE.
- FSM has two states, IDLE and SEND.
- IDLE:
  - in_ready=1.
  - When in_valid=1, register in_data and the decoded route on that edge, then enter SEND.
- SEND:
  - in_ready=0.
  - Exactly one bit of out_valid is high; out_data, out_sel and out_core are stable.
  - When out_ready of the selected bit is 1, the transfer completes on that edge; out_valid drops and the FSM returns to IDLE.
  - out_ready bits for non-selected outputs are ignored.
- Latency and throughput:
  - Capture at edge N; out_valid is high in cycle N+1.
  - With out_ready held high, throughput is 1 flit per 2 cycles.
  - No combinational path from in_* to out_*.
- Route decode (XY, computed on in_data at capture):
  - dest_x > local_x: east (sel 00).
  - dest_x < local_x: west (01).
  - dest_x equal and dest_y > local_y: north (10).
  - dest_x equal and dest_y < local_y: south (11).
  - Both equal: core (out_core=1, out_valid[4]).
  - Comparisons are unsigned, 2-bit.
- Out-of-range destination (dest_x >= MESH_X or dest_y >= MESH_Y):
  - Route to core.
  - Set route_err on the capture edge; it stays set until reset.
- Backpressure: SEND holds indefinitely while the selected out_ready=0. Data and select must not change while held.
- Reset mid-SEND: the held flit is discarded and all outputs return to their reset values next cycle.
- out_ready asserted for the selected output in the same cycle SEND is entered has no effect; completion is evaluated only while in SEND.

Optional Feature:
- Macro: ROUTE_SPLIT_STATS_EN.
- With the macro defined:
  - Adds five 16-bit counters exposed on output port stat_cnt (80 bits, 16 bits per output, same order as out_valid).
  - Each counter increments on every completed transfer to its output and wraps from 0xFFFF to 0.
  - All counters clear on reset.
- Without the macro: the port and the logic are absent, and behaviour is otherwise identical.

Test Plan:
- local=(1,1), in_data dest=(3,1), out_ready=5'b11111: out_valid=00001, out_sel=00, out_core=0 in the cycle after capture; next flit accepted 2 cycles after the first.
- local=(2,2), dests (0,2),(2,3),(2,0),(2,2) in sequence: out_sel=01,10,11 then out_core=1 with out_valid=10000; out_data matches each in_data.
- local=(1,1), dest=(0,1), out_ready[1]=0 for 10 cycles then 1: out_valid=00010 and out_data held for 10 cycles, in_ready=0 throughout, completion on the 11th edge.
- MESH_X=3, local=(0,0), dest=(3,0): routed to core (out_valid=10000); route_err=1 and stays 1 after subsequent legal flits.
- Reset asserted for 1 cycle during a stalled SEND: next cycle out_valid=0 and route_err=0; in_ready=1 the cycle after reset deasserts; a new flit then routes correctly.
- ROUTE_SPLIT_STATS_EN defined, 3 east and 2 core transfers: east counter=3, core counter=2, others 0; preload east counter to 0xFFFF, one more east transfer makes it 0.

Source files
------------

// File: rtl/route_split_ctrl.sv
// ============================================================================
// Module   : route_split_ctrl
// Brief    : XY route decode and valid/ready sequencing for the 1-to-5 split
//            stage. Optional per-output counters under ROUTE_SPLIT_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module route_split_ctrl #(
    parameter int WIDTH  = 11,
    parameter int MESH_X = 4,
    parameter int MESH_Y = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [1:0]       local_x_i,
    input  logic [1:0]       local_y_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       out_sel_o,
    output logic             out_core_o,
    output logic [4:0]       out_valid_o,
    input  logic [4:0]       out_ready_i,
    output logic             route_err_o
`ifdef ROUTE_SPLIT_STATS_EN
    ,
    output logic [79:0]      stat_cnt_o
`endif
);

    localparam logic [0:0]  c_IDLE   = 1'b0;
    localparam logic [0:0]  c_SEND   = 1'b1;
    localparam logic [31:0] c_MESH_X = MESH_X;
    localparam logic [31:0] c_MESH_Y = MESH_Y;

    logic [0:0]       r_state_q, r_state_d;
    logic             r_rdy_q, r_rdy_d;
    logic [WIDTH-1:0] r_data_q, r_data_d;
    logic [1:0]       r_sel_q, r_sel_d;
    logic             r_core_q, r_core_d;
    logic [4:0]       r_valid_q, r_valid_d;
    logic             r_err_q, r_err_d;

    logic [1:0]       w_dx, w_dy;
    logic             w_oor;
    logic [1:0]       w_sel_dec;
    logic             w_core_dec;
    logic [4:0]       w_vld_dec;
    logic             w_capture;
    logic             w_done;

    assign w_dx  = in_data_i[WIDTH-1 -: 2];
    assign w_dy  = in_data_i[WIDTH-3 -: 2];
    assign w_oor = ({30'd0, w_dx} >= c_MESH_X) || ({30'd0, w_dy} >= c_MESH_Y);

    // Out-of-range destinations are parked on the core port rather than dropped.
    always_comb begin
        w_sel_dec  = 2'b00;
        w_core_dec = 1'b0;
        if (w_oor)                  w_core_dec = 1'b1;
        else if (w_dx > local_x_i)  w_sel_dec  = 2'b00;
        else if (w_dx < local_x_i)  w_sel_dec  = 2'b01;
        else if (w_dy > local_y_i)  w_sel_dec  = 2'b10;
        else if (w_dy < local_y_i)  w_sel_dec  = 2'b11;
        else                        w_core_dec = 1'b1;
    end

    assign w_vld_dec = w_core_dec ? 5'b10000 : {1'b0, 4'b0001 << w_sel_dec};
    assign w_capture = (r_state_q == c_IDLE) && r_rdy_q && in_valid_i;
    assign w_done    = (r_state_q == c_SEND) && (|(r_valid_q & out_ready_i));

    always_comb begin
        r_state_d = r_state_q;
        r_data_d  = r_data_q;
        r_sel_d   = r_sel_q;
        r_core_d  = r_core_q;
        r_valid_d = r_valid_q;
        r_err_d   = r_err_q;
        if (w_capture) begin
            r_state_d = c_SEND;
            r_data_d  = in_data_i;
            r_sel_d   = w_sel_dec;
            r_core_d  = w_core_dec;
            r_valid_d = w_vld_dec;
            r_err_d   = r_err_q | w_oor;
        end else if (w_done) begin
            r_state_d = c_IDLE;
            r_valid_d = 5'b00000;
        end
        // Registered ready keeps in_ready low through reset and off the in_* path.
        r_rdy_d = (r_state_d == c_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state_q <= c_IDLE;
            r_rdy_q   <= 1'b0;
            r_data_q  <= '0;
            r_sel_q   <= 2'b00;
            r_core_q  <= 1'b0;
            r_valid_q <= 5'b00000;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_rdy_q   <= r_rdy_d;
            r_data_q  <= r_data_d;
            r_sel_q   <= r_sel_d;
            r_core_q  <= r_core_d;
            r_valid_q <= r_valid_d;
            r_err_q   <= r_err_d;
        end
    end

    assign in_ready_o  = r_rdy_q;
    assign out_data_o  = r_data_q;
    assign out_sel_o   = r_sel_q;
    assign out_core_o  = r_core_q;
    assign out_valid_o = r_valid_q;
    assign route_err_o = r_err_q;

`ifdef ROUTE_SPLIT_STATS_EN
    logic [4:0][15:0] r_stat_q;

    for (genvar gi = 0; gi < 5; gi++) begin : g_stat
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                r_stat_q[gi] <= 16'd0;
            end else if (w_done && r_valid_q[gi]) begin
                r_stat_q[gi] <= r_stat_q[gi] + 16'd1;
            end
        end
    end

    assign stat_cnt_o = r_stat_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_route_split_ctrl.sv
// ============================================================================
// Module   : tb_route_split_ctrl
// Brief    : Directed self-checking bench for route_split_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_route_split_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    int          n_tests = 0;
    int          n_fail  = 0;

    // Main instance, default mesh
    logic [1:0]  lx, ly;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_data;
    logic [10:0] out_data;
    logic [1:0]  out_sel;
    logic        out_core;
    logic [4:0]  out_valid;
    logic [4:0]  out_ready;
    logic        route_err;

    // Second instance with a 3-column mesh
    logic [1:0]  lx3, ly3;
    logic        in_valid3;
    logic        in_ready3;
    logic [10:0] in_data3;
    logic [10:0] out_data3;
    logic [1:0]  out_sel3;
    logic        out_core3;
    logic [4:0]  out_valid3;
    logic [4:0]  out_ready3;
    logic        route_err3;

`ifdef ROUTE_SPLIT_STATS_EN
    logic [79:0] stat_cnt;
    logic [79:0] stat_cnt3;
`endif

    always #5 clk = ~clk;

    route_split_ctrl #(.WIDTH(11), .MESH_X(4), .MESH_Y(4)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .local_x_i   (lx),
        .local_y_i   (ly),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_data_o  (out_data),
        .out_sel_o   (out_sel),
        .out_core_o  (out_core),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .route_err_o (route_err)
`ifdef ROUTE_SPLIT_STATS_EN
        ,
        .stat_cnt_o  (stat_cnt)
`endif
    );

    route_split_ctrl #(.WIDTH(11), .MESH_X(3), .MESH_Y(4)) dut3 (
        .clk_i       (clk),
        .reset_i     (reset),
        .local_x_i   (lx3),
        .local_y_i   (ly3),
        .in_valid_i  (in_valid3),
        .in_ready_o  (in_ready3),
        .in_data_i   (in_data3),
        .out_data_o  (out_data3),
        .out_sel_o   (out_sel3),
        .out_core_o  (out_core3),
        .out_valid_o (out_valid3),
        .out_ready_i (out_ready3),
        .route_err_o (route_err3)
`ifdef ROUTE_SPLIT_STATS_EN
        ,
        .stat_cnt_o  (stat_cnt3)
`endif
    );

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transfer on the main instance with all outputs ready.
    task automatic xfer(input logic [10:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    // Test 2 vectors: local=(2,2)
    logic [1:0] t2_dx   [4] = '{2'd0, 2'd2, 2'd2, 2'd2};
    logic [1:0] t2_dy   [4] = '{2'd2, 2'd3, 2'd0, 2'd2};
    logic [4:0] t2_vld  [4] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000};
    logic [1:0] t2_sel  [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic       t2_core [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        reset     = 1'b1;
        lx = 2'd1; ly = 2'd1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 5'b11111;
        lx3 = 2'd0; ly3 = 2'd0;
        in_valid3 = 1'b0;
        in_data3  = '0;
        out_ready3 = 5'b11111;

        tick();
        tick();
        chk("rst_in_ready",  in_ready,  1'b0);
        chk("rst_out_valid", out_valid, 5'b00000);
        chk("rst_out_sel",   out_sel,   2'b00);
        chk("rst_out_core",  out_core,  1'b0);
        chk("rst_out_data",  out_data,  11'd0);
        chk("rst_route_err", route_err, 1'b0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", in_ready, 1'b1);

        // Test 1: east routing and 2-cycle throughput
        in_data  = {2'd3, 2'd1, 7'h55};
        in_valid = 1'b1;
        tick();
        chk("t1_valid",  out_valid, 5'b00001);
        chk("t1_sel",    out_sel,   2'b00);
        chk("t1_core",   out_core,  1'b0);
        chk("t1_data",   out_data,  {2'd3, 2'd1, 7'h55});
        chk("t1_ready0", in_ready,  1'b0);
        in_data = {2'd3, 2'd1, 7'h2A};
        tick();
        chk("t1_done",   out_valid, 5'b00000);
        chk("t1_ready1", in_ready,  1'b1);
        tick();
        chk("t1_valid2", out_valid, 5'b00001);
        chk("t1_data2",  out_data,  {2'd3, 2'd1, 7'h2A});
        in_valid = 1'b0;
        tick();
        chk("t1_done2",  out_valid, 5'b00000);

        // Test 2: west, north, south, core from (2,2)
        lx = 2'd2; ly = 2'd2;
        for (int i = 0; i < 4; i++) begin
            in_data  = {t2_dx[i], t2_dy[i], 7'(8'h10 + i)};
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk("t2_valid", out_valid, t2_vld[i]);
            chk("t2_data",  out_data,  {t2_dx[i], t2_dy[i], 7'(8'h10 + i)});
            if (t2_core[i]) chk("t2_core", out_core, 1'b1);
            else begin
                chk("t2_sel",  out_sel,  t2_sel[i]);
                chk("t2_core", out_core, 1'b0);
            end
            tick();
            chk("t2_done", out_valid, 5'b00000);
        end

        // Test 3: backpressure on west for 10 cycles; other readies ignored
        lx = 2'd1; ly = 2'd1;
        out_ready = 5'b11101;
        in_data   = {2'd0, 2'd1, 7'h33};
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_valid", out_valid, 5'b00010);
            chk("t3_hold_data",  out_data,  {2'd0, 2'd1, 7'h33});
            chk("t3_hold_ready", in_ready,  1'b0);
            tick();
        end
        chk("t3_still_valid", out_valid, 5'b00010);
        out_ready = 5'b11111;
        tick();
        chk("t3_done_valid", out_valid, 5'b00000);
        chk("t3_done_ready", in_ready,  1'b1);

        // Test 4: out-of-range dest_x on the 3-column mesh
        in_data3  = {2'd3, 2'd0, 7'h44};
        in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        chk("t4_valid", out_valid3, 5'b10000);
        chk("t4_core",  out_core3,  1'b1);
        chk("t4_err",   route_err3, 1'b1);
        tick();
        in_data3  = {2'd1, 2'd0, 7'h45};
        in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        chk("t4_legal_valid", out_valid3, 5'b00001);
        chk("t4_err_sticky",  route_err3, 1'b1);
        tick();
        chk("t4_err_sticky2", route_err3, 1'b1);

        // Test 5: reset during a stalled SEND
        out_ready = 5'b00000;
        in_data   = {2'd0, 2'd1, 7'h66};
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        chk("t5_stall_valid", out_valid, 5'b00010);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rst_valid",  out_valid,  5'b00000);
        chk("t5_rst_data",   out_data,   11'd0);
        chk("t5_rst_err3",   route_err3, 1'b0);
        chk("t5_rst_err",    route_err,  1'b0);
        chk("t5_rst_ready",  in_ready,   1'b0);
        tick();
        chk("t5_ready_after", in_ready, 1'b1);
        out_ready = 5'b11111;
        in_data   = {2'd1, 2'd2, 7'h77};
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        chk("t5_new_valid", out_valid, 5'b00100);
        chk("t5_new_sel",   out_sel,   2'b10);
        chk("t5_new_data",  out_data,  {2'd1, 2'd2, 7'h77});
        tick();
        chk("t5_new_done",  out_valid, 5'b00000);

`ifdef ROUTE_SPLIT_STATS_EN
        // Optional counters: 3 east + 2 core, then wrap on east
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("st_clear", stat_cnt, 80'd0);
        lx = 2'd1; ly = 2'd1;
        for (int i = 0; i < 3; i++) xfer({2'd3, 2'd1, 7'h01});
        for (int i = 0; i < 2; i++) xfer({2'd1, 2'd1, 7'h02});
        chk("st_east",  stat_cnt[15:0],  16'd3);
        chk("st_west",  stat_cnt[31:16], 16'd0);
        chk("st_north", stat_cnt[47:32], 16'd0);
        chk("st_south", stat_cnt[63:48], 16'd0);
        chk("st_core",  stat_cnt[79:64], 16'd2);
        dut.r_stat_q[0] = 16'hFFFF;
        xfer({2'd2, 2'd1, 7'h03});
        chk("st_wrap", stat_cnt[15:0], 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
